pc_gen: RTL and testbench

Parametrised program-counter generator for the core's fetch stage; it generalises the fixed 32-bit hold/jump PC into a handshaked fetch-address source. It adds configurable address width, reset vector, fetch stride and hold-vector width, prioritised trap and jump redirects, and a valid/ready request interface to instruction memory. It sits between the control/hazard unit (hold, redirects) and the instruction-fetch bus; decode consumes `pc_o` and `flush_o`.

---
 rtl/core_pkg.sv | 21 ++
 rtl/pc_redirect_arb.sv | 33 +++
 rtl/pc_gen.sv | 143 ++++++++++++++
 tb/tb_pc_gen.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the fetch-stage PC generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: PC generator state encoding, default hold-vector width and the
// default reset vector.
package core_pkg;

   // BOOT: the single idle cycle after reset.
   // RUN : normal issue.
   // PEND: a redirect arrived while a request was stalled on the bus.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } pc_state_t;

   localparam int          HOLD_W_DEF  = 3;
   localparam logic [31:0] RST_VEC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority select of the redirect target (trap over jump) with fetch alignment.
// Latency: combinational, 0 cycles.
// Backpressure: none; the strobes are sampled by pc_gen wherever they apply.
//
// Ports:
//   trap, trap_addr   trap redirect strobe and target (highest priority)
//   jump, jump_addr   branch/jump redirect strobe and target
//   redir_vld         some redirect is requested this cycle
//   redir_trap        the selected redirect is the trap
//   redir_addr        selected target with the low log2(FETCH_BYTES) bits cleared
module pc_redirect_arb #(
   parameter int XLEN        = 32,
   parameter int FETCH_BYTES = 4
) (
   input  logic            trap,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            jump,
   input  logic [XLEN-1:0] jump_addr,
   output logic            redir_vld,
   output logic            redir_trap,
   output logic [XLEN-1:0] redir_addr
);

   // FETCH_BYTES is a power of two (4 or 8), so FETCH_BYTES-1 is the low-bit mask.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(FETCH_BYTES - 1));

   always_comb begin
      redir_vld  = trap | jump;
      redir_trap = trap;
      redir_addr = (trap ? trap_addr : jump_addr) & ALIGN_MASK;
   end

endmodule

// File: rtl/pc_gen.sv
// Handshaked fetch-address generator with trap/jump redirects and hold.
// Latency: redirect -> new req_addr_o in 1 cycle (1 cycle after a stalled handshake completes).
// Backpressure: req_valid_o/req_addr_o held stable while req_ready_i is low.
//
// Ports:
//   clk, rst                   core clock, asynchronous active-high reset
//   hold_i                     any set bit stalls issue at the next request boundary
//   trap_i / trap_addr_i       trap redirect (highest priority)
//   jump_i / jump_addr_i       branch/jump redirect
//   req_valid_o / req_addr_o   fetch request to instruction memory
//   req_ready_i                fetch bus accepts the request
//   pc_o                       PC of the most recently accepted (non-discarded) fetch
//   flush_o                    registered 1-cycle pulse per applied redirect
module pc_gen
   import core_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RST_VEC     = XLEN'(RST_VEC_DEF),
   parameter int              FETCH_BYTES = 4,
   parameter int              HOLD_W      = HOLD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [HOLD_W-1:0] hold_i,
   input  logic              trap_i,
   input  logic [XLEN-1:0]   trap_addr_i,
   input  logic              jump_i,
   input  logic [XLEN-1:0]   jump_addr_i,
   output logic              req_valid_o,
   output logic [XLEN-1:0]   req_addr_o,
   input  logic              req_ready_i,
   output logic [XLEN-1:0]   pc_o,
   output logic              flush_o
);

   localparam logic [XLEN-1:0] STRIDE = XLEN'(FETCH_BYTES);

   pc_state_t       state_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] pc_q;
   logic            flush_q;
   logic            stall_q;      // last RUN cycle ended with valid && !ready
   logic [XLEN-1:0] pend_addr_q;
   logic            pend_trap_q;

   logic            redir_vld;
   logic            redir_trap;
   logic [XLEN-1:0] redir_addr;
   logic            hold_any;
   logic            stalled;
   logic            take_new;
   logic [XLEN-1:0] pend_addr_nxt;
   logic            pend_trap_nxt;

   pc_redirect_arb #(
      .XLEN        (XLEN),
      .FETCH_BYTES (FETCH_BYTES)
   ) u_arb (
      .trap       (trap_i),
      .trap_addr  (trap_addr_i),
      .jump       (jump_i),
      .jump_addr  (jump_addr_i),
      .redir_vld  (redir_vld),
      .redir_trap (redir_trap),
      .redir_addr (redir_addr)
   );

   assign hold_any = |hold_i;

   // Hold only gates a fresh request; an offered-but-unaccepted request
   // (stall_q, or anything in PEND) must stay up until it transfers.
   assign req_valid_o = (state_q == ST_PEND) ||
                        ((state_q == ST_RUN) && (!hold_any || stall_q));
   assign stalled     = req_valid_o && !req_ready_i;

   // Merge a new redirect into the pending one: a trap always replaces,
   // a jump never displaces a pending trap.
   assign take_new      = redir_vld && (redir_trap || !pend_trap_q);
   assign pend_addr_nxt = take_new ? redir_addr : pend_addr_q;
   assign pend_trap_nxt = take_new ? redir_trap : pend_trap_q;

   assign req_addr_o = addr_q;
   assign pc_o       = pc_q;
   assign flush_o    = flush_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_BOOT;
         addr_q      <= RST_VEC;
         pc_q        <= RST_VEC;
         flush_q     <= 1'b0;
         stall_q     <= 1'b0;
         pend_addr_q <= '0;
         pend_trap_q <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         case (state_q)
            // Redirects are not expected before the first request; ignore them.
            ST_BOOT: state_q <= ST_RUN;

            ST_RUN: begin
               if (stalled) begin
                  stall_q <= 1'b1;
                  if (redir_vld) begin
                     state_q     <= ST_PEND;
                     pend_addr_q <= redir_addr;
                     pend_trap_q <= redir_trap;
                  end
               end else begin
                  stall_q <= 1'b0;
                  if (req_valid_o) begin
                     pc_q <= addr_q;
                  end
                  if (redir_vld) begin
                     addr_q  <= redir_addr;
                     flush_q <= 1'b1;
                  end else if (req_valid_o) begin
                     addr_q <= addr_q + STRIDE;   // wraps modulo 2^XLEN
                  end
               end
            end

            ST_PEND: begin
               if (req_ready_i) begin
                  // The accepted fetch is the one being flushed, so pc_q keeps its value.
                  state_q     <= ST_RUN;
                  stall_q     <= 1'b0;
                  addr_q      <= pend_addr_nxt;
                  flush_q     <= 1'b1;
                  pend_addr_q <= '0;
                  pend_trap_q <= 1'b0;
               end else begin
                  pend_addr_q <= pend_addr_nxt;
                  pend_trap_q <= pend_trap_nxt;
               end
            end

            default: state_q <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the fetch-address rules.
module tb_pc_gen;

   localparam int          XLEN = 32;
   localparam logic [31:0] RV   = 32'h8000_0000;
   localparam int          FB   = 4;
   localparam int          HW   = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [HW-1:0] hold_i = '0;
   logic          trap_i = 1'b0;
   logic [31:0]   trap_addr_i = '0;
   logic          jump_i = 1'b0;
   logic [31:0]   jump_addr_i = '0;
   logic          req_ready_i = 1'b0;
   logic          req_valid_o;
   logic [31:0]   req_addr_o;
   logic [31:0]   pc_o;
   logic          flush_o;

   int checks = 0;
   int failures = 0;

   pc_gen #(
      .XLEN        (XLEN),
      .RST_VEC     (RV),
      .FETCH_BYTES (FB),
      .HOLD_W      (HW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hold_i      (hold_i),
      .trap_i      (trap_i),
      .trap_addr_i (trap_addr_i),
      .jump_i      (jump_i),
      .jump_addr_i (jump_addr_i),
      .req_valid_o (req_valid_o),
      .req_addr_o  (req_addr_o),
      .req_ready_i (req_ready_i),
      .pc_o        (pc_o),
      .flush_o     (flush_o)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_boot;        // first cycle after reset: nothing offered
   bit          m_offered;     // a request was shown last cycle and not taken
   bit          m_pend_vld;
   bit          m_pend_trap;
   logic [31:0] m_pend_addr;
   logic [31:0] m_addr;
   logic [31:0] m_pc;
   bit          m_flush;

   function automatic logic [31:0] align(input logic [31:0] a);
      return (a / FB) * FB;
   endfunction

   function automatic bit m_valid();
      if (m_boot) return 1'b0;
      if (m_pend_vld || m_offered) return 1'b1;
      return (hold_i == '0);
   endfunction

   task automatic model_reset();
      m_boot = 1; m_offered = 0; m_pend_vld = 0; m_pend_trap = 0;
      m_pend_addr = '0; m_addr = RV; m_pc = RV; m_flush = 0;
   endtask

   task automatic model_step();
      bit v, acc, nf, rd, rt;
      logic [31:0] tgt;
      v   = m_valid();
      acc = v && req_ready_i;
      nf  = 0;
      rd  = trap_i || jump_i;
      rt  = trap_i;
      tgt = trap_i ? align(trap_addr_i) : align(jump_addr_i);
      if (m_boot) begin
         m_boot = 0;
      end else if (m_pend_vld) begin
         if (rd && (rt || !m_pend_trap)) begin
            m_pend_addr = tgt; m_pend_trap = rt;
         end
         if (acc) begin
            m_addr = m_pend_addr; nf = 1; m_pend_vld = 0; m_pend_trap = 0; m_offered = 0;
         end
      end else if (v && !req_ready_i) begin
         m_offered = 1;
         if (rd) begin
            m_pend_vld = 1; m_pend_addr = tgt; m_pend_trap = rt;
         end
      end else begin
         m_offered = 0;
         if (acc) m_pc = m_addr;
         if (rd) begin
            m_addr = tgt; nf = 1;
         end else if (acc) begin
            m_addr = 32'((64'(m_addr) + 64'(FB)) % 64'h1_0000_0000);
         end
      end
      m_flush = nf;
   endtask

   // Drive inputs after the edge and let combinational outputs settle.
   task automatic apply(input logic [HW-1:0] h, input logic t, input logic [31:0] ta,
                        input logic j, input logic [31:0] ja, input logic r);
      hold_i = h; trap_i = t; trap_addr_i = ta; jump_i = j; jump_addr_i = ja; req_ready_i = r;
      #1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      apply('0, 0, '0, 0, '0, 1);
      @(posedge clk); #1;
      checks++;
      if ({req_valid_o, req_addr_o, pc_o, flush_o} !== {1'b0, RV, RV, 1'b0}) begin
         failures++;
         $display("FAIL reset_vals got v=%b a=%h pc=%h f=%b exp v=0 a=%h pc=%h f=0",
                  req_valid_o, req_addr_o, pc_o, flush_o, RV, RV);
      end
      rst = 1'b0;
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if (req_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL boot_valid got %b exp 0", req_valid_o);
      end
      tick();
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         apply('0, 0, '0, 0, '0, 1);
         checks++;
         if ({req_valid_o, req_addr_o, pc_o} !==
             {1'b1, RV + 32'(4 * i), (i == 0) ? RV : RV + 32'(4 * (i - 1))}) begin
            failures++;
            $display("FAIL seq_%0d got v=%b a=%h pc=%h exp v=1 a=%h", i, req_valid_o,
                     req_addr_o, pc_o, RV + 32'(4 * i));
         end
         tick();
      end
   endtask

   task automatic test_hold();
      logic [31:0] frozen;
      frozen = m_addr;
      for (int i = 0; i < 3; i++) begin
         apply(3'b010, 0, '0, 0, '0, 1);
         checks++;
         if ({req_valid_o, req_addr_o, flush_o} !== {1'b0, frozen, 1'b0}) begin
            failures++;
            $display("FAIL hold_%0d got v=%b a=%h f=%b exp v=0 a=%h f=0", i, req_valid_o,
                     req_addr_o, flush_o, frozen);
         end
         tick();
      end
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_valid_o, req_addr_o} !== {1'b1, frozen}) begin
         failures++;
         $display("FAIL hold_resume got v=%b a=%h exp v=1 a=%h", req_valid_o, req_addr_o, frozen);
      end
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if (req_addr_o !== frozen + 32'd4) begin
         failures++;
         $display("FAIL hold_next got a=%h exp %h", req_addr_o, frozen + 32'd4);
      end
   endtask

   task automatic test_jump();
      apply('0, 0, '0, 1, 32'h0000_1002, 1);
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_addr_o, flush_o} !== {32'h0000_1000, 1'b1}) begin
         failures++;
         $display("FAIL jump_tgt got a=%h f=%b exp a=00001000 f=1", req_addr_o, flush_o);
      end
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_addr_o, flush_o} !== {32'h0000_1004, 1'b0}) begin
         failures++;
         $display("FAIL jump_after got a=%h f=%b exp a=00001004 f=0", req_addr_o, flush_o);
      end
   endtask

   task automatic test_trap_jump();
      apply('0, 1, 32'h0000_0100, 1, 32'h0000_2000, 1);
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_addr_o, flush_o} !== {32'h0000_0100, 1'b1}) begin
         failures++;
         $display("FAIL trapjump_tgt got a=%h f=%b exp a=00000100 f=1", req_addr_o, flush_o);
      end
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if (flush_o !== 1'b0) begin
         failures++;
         $display("FAIL trapjump_single got f=%b exp 0", flush_o);
      end
   endtask

   task automatic test_stall_jump();
      logic [31:0] held_addr, held_pc;
      held_addr = m_addr;
      held_pc   = m_pc;
      for (int i = 1; i <= 4; i++) begin
         apply('0, 0, '0, (i == 2), 32'h0000_3000, 0);
         checks++;
         if ({req_valid_o, req_addr_o, flush_o} !== {1'b1, held_addr, 1'b0}) begin
            failures++;
            $display("FAIL stall_%0d got v=%b a=%h f=%b exp v=1 a=%h f=0", i, req_valid_o,
                     req_addr_o, flush_o, held_addr);
         end
         tick();
      end
      apply('0, 0, '0, 0, '0, 1);
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_addr_o, flush_o, pc_o} !== {32'h0000_3000, 1'b1, held_pc}) begin
         failures++;
         $display("FAIL stall_redir got a=%h f=%b pc=%h exp a=00003000 f=1 pc=%h",
                  req_addr_o, flush_o, pc_o, held_pc);
      end
      tick();
   endtask

   task automatic test_wrap();
      apply('0, 0, '0, 1, 32'hFFFF_FFFC, 1);
      tick();
      apply('0, 0, '0, 0, '0, 1);
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_addr_o, pc_o, flush_o} !== {32'h0000_0000, 32'hFFFF_FFFC, 1'b0}) begin
         failures++;
         $display("FAIL wrap got a=%h pc=%h f=%b exp a=00000000 pc=fffffffc f=0",
                  req_addr_o, pc_o, flush_o);
      end
      tick();
   endtask

   task automatic test_reset_pend();
      apply('0, 0, '0, 1, 32'h0000_4000, 0);
      tick();
      apply('0, 0, '0, 0, '0, 0);
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({req_valid_o, req_addr_o, pc_o, flush_o} !== {1'b0, RV, RV, 1'b0}) begin
         failures++;
         $display("FAIL rst_pend got v=%b a=%h pc=%h f=%b exp v=0 a=%h pc=%h f=0",
                  req_valid_o, req_addr_o, pc_o, flush_o, RV, RV);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_valid_o, flush_o} !== 2'b00) begin
         failures++;
         $display("FAIL rst_pend_boot got v=%b f=%b exp v=0 f=0", req_valid_o, flush_o);
      end
      tick();
      apply('0, 0, '0, 0, '0, 1);
      checks++;
      if ({req_valid_o, req_addr_o, flush_o} !== {1'b1, RV, 1'b0}) begin
         failures++;
         $display("FAIL rst_pend_run got v=%b a=%h f=%b exp v=1 a=%h f=0",
                  req_valid_o, req_addr_o, flush_o, RV);
      end
      tick();
   endtask

   task automatic test_random();
      logic [HW-1:0] h;
      logic t, j, r;
      for (int n = 0; n < 600; n++) begin
         h = ($urandom_range(0, 3) == 0) ? HW'($urandom) : '0;
         t = ($urandom_range(0, 15) == 0);
         j = ($urandom_range(0, 6) == 0);
         r = ($urandom_range(0, 2) != 0);
         apply(h, t, $urandom, j, $urandom, r);
         checks++;
         if ({req_valid_o, req_addr_o, pc_o, flush_o} !== {m_valid(), m_addr, m_pc, m_flush}) begin
            failures++;
            $display("FAIL rand_%0d got v=%b a=%h pc=%h f=%b exp v=%b a=%h pc=%h f=%b", n,
                     req_valid_o, req_addr_o, pc_o, flush_o, m_valid(), m_addr, m_pc, m_flush);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_hold();
      test_jump();
      test_trap_jump();
      test_stall_jump();
      test_wrap();
      test_reset_pend();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
